// File: rtl/uart_tx_if.sv
// Core-side bundle for the UART transmitter: push strobe/data toward the
// transmitter, FIFO status and the serial line back.
interface uart_tx_if;
    logic       TxD_start;
    logic [7:0] TxD_data;
    logic       TxD_full;
    logic       TxD_busy;
    logic       TxD_overflow;
    logic       TxD;

    modport master (
        output TxD_start, TxD_data,
        input  TxD_full, TxD_busy, TxD_overflow, TxD
    );

    modport slave (
        input  TxD_start, TxD_data,
        output TxD_full, TxD_busy, TxD_overflow, TxD
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Queued frames go out back to back; every output is registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input logic        clk,
    input logic        RST,
    uart_tx_if.slave   tx_if
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            push_s, pop_s, baud_done_s, nonempty_s;

    assign baud_done_s = (baud_q == BAUD_ZERO);
    assign nonempty_s  = (count_q != CNT_ZERO);
    // A full FIFO rejects a push even when a pop frees a slot on the same edge.
    assign push_s      = tx_if.TxD_start & (count_q != CNT_FULL);

    // Frame sequencer: pops a byte, then walks start, 8 data and stop bits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (nonempty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_done_s) begin
                    baud_d  = BAUD_LOAD;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q - BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_done_s) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    baud_d  = baud_q - BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_done_s) begin
                    if (nonempty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d  = baud_q - BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = BAUD_ZERO;
            end
        endcase
    end

    // FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) | (count_d != CNT_ZERO);
        full_d = (count_d == CNT_FULL);
        ovf_d  = tx_if.TxD_start & (count_q == CNT_FULL);
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            baud_q   <= BAUD_ZERO;
            idx_q    <= 3'd0;
            shift_q  <= 8'h00;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= CNT_ZERO;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= tx_if.TxD_data;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign tx_if.TxD          = txd_q;
    assign tx_if.TxD_busy     = busy_q;
    assign tx_if.TxD_full     = full_q;
    assign tx_if.TxD_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame tables, directed corner cases and
// random pushes compared every cycle against a frame-level reference model.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_if bif ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .RST   (rst_n),
        .tx_if (bif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a byte queue plus "frame in flight, cycle t of 40".
    logic [7:0] mq [$];
    bit         m_active;
    int         m_t;
    logic [7:0] m_cur;
    bit         m_ovf;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit k = line level during bit period k
    } vec_t;
    vec_t vecs [4];

    logic samp [FRAME * 5];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_cur    = 8'h00;
        m_ovf    = 1'b0;
    endfunction

    function automatic void model_edge(logic st, logic [7:0] d);
        int pre;
        if (!rst_n) begin
            model_clear();
            return;
        end
        pre = mq.size();
        if (m_active) begin
            m_t++;
            if (m_t == FRAME) begin
                m_active = 1'b0;
                if (pre > 0) begin
                    m_cur    = mq.pop_front();
                    m_active = 1'b1;
                    m_t      = 0;
                end
            end
        end else if (pre > 0) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
        end
        m_ovf = st && (pre == DEPTH);
        if (st && (pre < DEPTH)) mq.push_back(d);
    endfunction

    function automatic logic model_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic void check_model();
        chk("model_TxD",      bif.TxD,          model_txd());
        chk("model_busy",     bif.TxD_busy,     m_active || (mq.size() != 0));
        chk("model_full",     bif.TxD_full,     mq.size() == DEPTH);
        chk("model_overflow", bif.TxD_overflow, m_ovf);
    endfunction

    task automatic step(input logic st, input logic [7:0] d);
        bif.TxD_start = st;
        bif.TxD_data  = d;
        @(posedge clk);
        model_edge(st, d);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int   edges;
        logic prev;
        int   first_unfull;
        int   div;
        int   lvl [5];

        bif.TxD_start = 1'b0;
        bif.TxD_data  = 8'h00;
        model_clear();

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};

        // Reset state and quiet line.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_TxD",      bif.TxD,          1'b1);
        chk("reset_busy",     bif.TxD_busy,     1'b0);
        chk("reset_full",     bif.TxD_full,     1'b0);
        chk("reset_overflow", bif.TxD_overflow, 1'b0);
        edges = 0;
        prev  = bif.TxD;
        repeat (50) begin
            step(1'b0, 8'h00);
            if (bif.TxD !== prev) edges++;
            prev = bif.TxD;
        end
        chk("reset_no_edge", edges, 0);

        // Single frames from the table.
        for (int v = 0; v < 4; v++) begin
            step(1'b1, vecs[v].data);
            for (int c = 0; c < FRAME; c++) begin
                step(1'b0, 8'h00);
                chk("frame_line", bif.TxD, vecs[v].line[c / CPB]);
                chk("frame_busy", bif.TxD_busy, 1'b1);
            end
            step(1'b0, 8'h00);
            chk("frame_busy_fall", bif.TxD_busy, 1'b0);
        end

        // Burst of five, an overflow attempt, then drain.
        first_unfull = -1;
        for (int i = 0; i < FRAME * 5 + 6; i++) begin
            if (i < 5)       step(1'b1, 8'(i + 1));
            else if (i == 5) step(1'b1, 8'hEE);
            else             step(1'b0, 8'h00);
            if (i >= 1 && i <= FRAME * 5) samp[i-1] = bif.TxD;
            if (i == 4) chk("burst_full", bif.TxD_full, 1'b1);
            if (i == 5) chk("overflow_pulse", bif.TxD_overflow, 1'b1);
            if (i == 6) chk("overflow_one_cycle", bif.TxD_overflow, 1'b0);
            if (i > 5 && first_unfull < 0 && bif.TxD_full === 1'b0) first_unfull = i;
            if (i == FRAME * 5 + 1) chk("burst_busy_fall", bif.TxD_busy, 1'b0);
        end
        chk("full_clear_after_pop", first_unfull, FRAME + 1);
        for (int f = 0; f < 5; f++) begin
            logic [7:0] got;
            for (int b = 0; b < 8; b++) got[b] = samp[f*FRAME + (b+1)*CPB + 1];
            chk("burst_start", samp[f*FRAME], 1'b0);
            chk("burst_byte", got, 8'(f + 1));
            chk("burst_stop", samp[f*FRAME + 9*CPB + 1], 1'b1);
        end

        // Reset during data bit 3 of 0x5A with two bytes still queued.
        step(1'b1, 8'h5A);
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        while (!(m_active && m_t == 4 * CPB + 1)) step(1'b0, 8'h00);
        chk("midframe_queued", mq.size(), 2);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_rst_TxD",  bif.TxD,      1'b1);
        chk("async_rst_busy", bif.TxD_busy, 1'b0);
        chk("async_rst_full", bif.TxD_full, 1'b0);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst_n = 1'b1;
        edges = 0;
        prev  = bif.TxD;
        repeat (50) begin
            step(1'b0, 8'h00);
            if (bif.TxD !== prev) edges++;
            prev = bif.TxD;
        end
        chk("post_rst_no_edge", edges, 0);
        chk("post_rst_busy", bif.TxD_busy, 1'b0);

        // Random pushes at several densities, checked by the model each cycle.
        lvl[0] = 1; lvl[1] = 0; lvl[2] = 3; lvl[3] = 40; lvl[4] = 12;
        for (int p = 0; p < 5; p++) begin
            div = lvl[p];
            for (int n = 0; n < 300; n++) begin
                step(($urandom_range(0, div) == 0), 8'($urandom));
            end
        end
        repeat (FRAME * (DEPTH + 2)) step(1'b0, 8'h00);
        chk("drain_busy", bif.TxD_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the board's `TxD` pin: it accepts bytes from the core-side `TxD_start`/`TxD_data` strobe and shifts them out as 8N1 asynchronous frames, LSB first. A small FIFO lets software-driven bursts be queued without stalling the core. The block sits beside the clock controller in the top level, is clocked by the same `clk`, and is the transmit counterpart of the `RxD`/`RxD_data_ready` receive path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: `clk` cycles per serial bit (50 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 4: byte entries in the transmit FIFO; power of two, ≥ 2.

Ports:
- `clk` input 1: the only clock; all state updates on the rising edge.
- `RST` input 1: reset, asynchronous, active-low. Asserting it forces all state to reset values immediately; release is sampled on `clk`.
- `TxD_start` input 1: push strobe; one byte is offered per cycle it is high.
- `TxD_data` input 8: byte pushed when `TxD_start` is high and `TxD_full` is low.
- `TxD_full` output 1: FIFO holds `FIFO_DEPTH` entries; pushes are rejected.
- `TxD_busy` output 1: FSM not IDLE, or FIFO non-empty.
- `TxD_overflow` output 1: one-cycle pulse when a push is rejected.
- `TxD` output 1: serial line; idle high.

## Operation
- Reset values: `TxD`=1, `TxD_full`=0, `TxD_busy`=0, `TxD_overflow`=0; FIFO empty; FSM in IDLE; baud counter 0.
- FIFO: circular buffer with read/write pointers and a count of width clog2(`FIFO_DEPTH`)+1.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push is accepted iff `TxD_start`=1 and the registered count < `FIFO_DEPTH`.
  - `TxD_full` is taken from the registered count. A push while full is rejected even if a pop happens on the same edge; the byte is dropped and `TxD_overflow` pulses on the next cycle.
  - A push and a pop on the same edge leave the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register, load the baud counter with `CLKS_PER_BIT`-1 and go to START. Otherwise `TxD`=1.
  - START: `TxD`=0. When the baud counter reaches 0, reload it, set bit index to 0 and go to DATA.
  - DATA: `TxD`=shift[0]. On each baud expiry, shift right and increment the index. After the expiry with index 7, go to STOP.
  - STOP: `TxD`=1. On baud expiry: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- `TxD` is registered and glitch-free; it changes only on state or bit boundaries.

## Timing
- A byte accepted at edge E0 is popped at E1 when the FSM is IDLE. `TxD` falls after E1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles, so a frame is 10×`CLKS_PER_BIT` cycles from the falling edge of the start bit to the end of the stop bit.
- Queued frames are contiguous: the next start bit begins on the cycle immediately after the previous stop bit ends.
- `TxD_busy` rises the cycle after the accepting edge. It falls the cycle after the final stop bit completes with the FIFO empty.
- `TxD_full` deasserts the cycle after a pop from a full FIFO.
- `RST` asserted mid-frame: `TxD` returns high immediately, the FIFO is flushed and the partial frame is abandoned. The first frame after release starts only on a new push.

## Test plan
Benches use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: hold `RST`=0 for 3 cycles, then release → `TxD`=1, `TxD_busy`=0, `TxD_full`=0, `TxD_overflow`=0; no `TxD` edge for 50 cycles.
- Single byte: push 0xA5 at edge E0 → `TxD` low for cycles E1–E4. Data bits 1,0,1,0,0,1,0,1, 4 cycles each, then stop high for 4 cycles. `TxD_busy` falls 40 cycles after E1.
- Burst: push 0x01, 0x02, 0x03, 0x04, 0x05 on 5 consecutive edges → all five accepted (the first is popped at the second edge). `TxD_full`=1 after the fifth push. Five contiguous frames span 200 cycles with no idle high gap between stop and start bits.
- Overflow: with the FIFO full, push 0xEE → `TxD_overflow` pulses for 1 cycle and 0xEE never appears on `TxD`. `TxD_full` clears the cycle after the next pop.
- Extremes: send 0x00 then 0xFF → 0x00 gives 36 consecutive low cycles (start plus data) then a 4-cycle stop. 0xFF gives a 4-cycle start low then 36 high cycles.
- Reset mid-frame: assert `RST` during bit 3 of 0x5A with 2 bytes still queued → `TxD`=1 within the same cycle (asynchronous). After release the line stays idle and `TxD_busy`=0 with no residual frames.
